// File: rtl/prio_arbiter_rr_pkg.sv
// Shared types and helpers for the prio_arbiter_rr request arbiter.
package prio_arbiter_rr_pkg;

  // Arbiter ownership state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Arbitration mode encodings on the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 with a floor of 1 so that derived widths never collapse to 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'd1 << i) < value) ? (i + 1) : r;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_arbiter_rr_if.sv
// Request/grant bundle between the masters and the arbiter.
interface prio_arbiter_rr_if #(
  parameter int N = 8
);
  import prio_arbiter_rr_pkg::*;

  localparam int W = clog2(N);

  logic [N-1:0] req;
  logic         mode;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  modport master (
    output req, mode,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, mode,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/prio_arbiter_rr_prio_pick.sv
// Combinational highest-set-index encoder with a found flag.
module prio_pick
  import prio_arbiter_rr_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan upward so the highest set bit is the last one to overwrite idx.
  always_comb begin
    idx   = {W{1'b0}};
    found = |vec;
    for (int i = 0; i < N; i++) begin
      idx = vec[i] ? W'(i) : idx;
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter: fixed (highest index) or round-robin priority,
// grant held until release, optional hold-timeout forced release.
module prio_arbiter_rr
  import prio_arbiter_rr_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input logic              clk,
  input logic              rst_n,
  prio_arbiter_rr_if.slave bus
);

  localparam int   W       = clog2(N);
  localparam int   CW      = clog2(MAX_HOLD + 1);
  localparam logic HOLD_EN = (MAX_HOLD != 0);

  state_t        state_r, state_n;
  logic [N-1:0]  gnt_r, gnt_n;
  logic [W-1:0]  gnt_idx_r, gnt_idx_n;
  logic          gnt_valid_r, gnt_valid_n;
  logic          timeout_r, timeout_n;
  logic [CW-1:0] hold_cnt_r, hold_cnt_n;
  logic [W-1:0]  rr_ptr_r, rr_ptr_n;

  logic          release_s, expire_s;
  logic [N-1:0]  cand_s;
  logic [2*N-1:0] dbl_s, rot_full_s;
  logic [N-1:0]  rot_s;
  logic [W-1:0]  fix_idx_s, rot_idx_s, rr_idx_s, win_idx_s, prev_ptr_s;
  logic          fix_found_s, rot_found_s, win_found_s;
  logic [W+1:0]  sum_s, sub_s;
  logic [N-1:0]  win_onehot_s;

  // A holder leaves either by dropping its request or by exhausting its hold
  // budget; a drop on the expiry cycle counts as a plain release.
  assign release_s = (state_r == GRANT) && !bus.req[gnt_idx_r];
  assign expire_s  = HOLD_EN && (state_r == GRANT) && bus.req[gnt_idx_r] &&
                     (hold_cnt_r == CW'(MAX_HOLD));

  // On expiry the current holder sits out this arbitration round.
  assign cand_s = expire_s ? (bus.req & ~gnt_r) : bus.req;

  prio_pick #(.N(N)) u_pick_fixed (
    .vec   (cand_s),
    .idx   (fix_idx_s),
    .found (fix_found_s)
  );

  // Rotate so rr_ptr lands on the top bit, then let the same encoder search
  // downward from there.
  assign dbl_s      = {cand_s, cand_s};
  assign rot_full_s = dbl_s >> ({1'b0, rr_ptr_r} + {{W{1'b0}}, 1'b1});
  assign rot_s      = rot_full_s[N-1:0];

  prio_pick #(.N(N)) u_pick_rr (
    .vec   (rot_s),
    .idx   (rot_idx_s),
    .found (rot_found_s)
  );

  // Undo the rotation modulo N (sum is below 2N, so one subtraction suffices).
  assign sum_s    = {2'b00, rot_idx_s} + {2'b00, rr_ptr_r} + {{(W+1){1'b0}}, 1'b1};
  assign sub_s    = sum_s - (W+2)'(N);
  assign rr_idx_s = (sum_s >= (W+2)'(N)) ? sub_s[W-1:0] : sum_s[W-1:0];

  assign win_idx_s    = (bus.mode == MODE_RR) ? rr_idx_s : fix_idx_s;
  assign win_found_s  = (bus.mode == MODE_RR) ? rot_found_s : fix_found_s;
  assign win_onehot_s = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
  assign prev_ptr_s   = (gnt_idx_r == {W{1'b0}}) ? W'(N - 1) : (gnt_idx_r - W'(1'b1));

  // Next-state and next-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_n     = state_r;
    gnt_n       = gnt_r;
    gnt_idx_n   = gnt_idx_r;
    gnt_valid_n = gnt_valid_r;
    timeout_n   = 1'b0;
    hold_cnt_n  = hold_cnt_r;
    rr_ptr_n    = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_n     = GRANT;
          gnt_n       = win_onehot_s;
          gnt_idx_n   = win_idx_s;
          gnt_valid_n = 1'b1;
          hold_cnt_n  = CW'(1'b1);
        end else begin
          state_n     = IDLE;
          gnt_n       = {N{1'b0}};
          gnt_idx_n   = {W{1'b0}};
          gnt_valid_n = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          rr_ptr_n = prev_ptr_s;
          if (win_found_s) begin
            gnt_n      = win_onehot_s;
            gnt_idx_n  = win_idx_s;
            hold_cnt_n = CW'(1'b1);
          end else begin
            state_n     = IDLE;
            gnt_n       = {N{1'b0}};
            gnt_idx_n   = {W{1'b0}};
            gnt_valid_n = 1'b0;
            hold_cnt_n  = {CW{1'b0}};
          end
        end else if (expire_s) begin
          rr_ptr_n   = prev_ptr_s;
          timeout_n  = 1'b1;
          hold_cnt_n = CW'(1'b1);
          if (win_found_s) begin
            gnt_n     = win_onehot_s;
            gnt_idx_n = win_idx_s;
          end else begin
            gnt_n     = gnt_r;
            gnt_idx_n = gnt_idx_r;
          end
        end else begin
          if (HOLD_EN && (hold_cnt_r != CW'(MAX_HOLD))) begin
            hold_cnt_n = hold_cnt_r + CW'(1'b1);
          end else begin
            hold_cnt_n = hold_cnt_r;
          end
        end
      end
      default: begin
        state_n     = IDLE;
        gnt_n       = {N{1'b0}};
        gnt_idx_n   = {W{1'b0}};
        gnt_valid_n = 1'b0;
        hold_cnt_n  = {CW{1'b0}};
      end
    endcase
  end

  // State, grant outputs, hold counter and rotation pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= {N{1'b0}};
      gnt_idx_r   <= {W{1'b0}};
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      hold_cnt_r  <= {CW{1'b0}};
      rr_ptr_r    <= W'(N - 1);
    end else begin
      state_r     <= state_n;
      gnt_r       <= gnt_n;
      gnt_idx_r   <= gnt_idx_n;
      gnt_valid_r <= gnt_valid_n;
      timeout_r   <= timeout_n;
      hold_cnt_r  <= hold_cnt_n;
      rr_ptr_r    <= rr_ptr_n;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule
